// File: rtl/iddr2_rx_align.sv
// iddr2_rx_align: word-alignment controller for a bank of IDDR2 DDR input lanes.
// Each lane's rising/falling samples are shifted into a 2*WORD_W history. A lane
// word is a WORD_W window into that history at the lane's bit-slip offset.
// Training flushes the IDDR2 bank, fills the history, then slips each lane until
// it repeatedly matches TRAIN_PAT. Once all lanes lock, aligned words stream out.
//
// Output handshake: word_valid is a one-cycle strobe with no ready/backpressure.
// The receiver must take word_out in every cycle where word_valid=1. word_out
// holds its value between strobes.
module iddr2_rx_align #(
    parameter int                LANES     = 2,
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] TRAIN_PAT = 8'hA5,
    parameter int                MATCH_CNT = 4,
    parameter int                FLUSH_CYC = 4
) (
    input  logic                              C0,
    input  logic                              R,
    input  logic                              train,
    input  logic [LANES-1:0]                  q0,
    input  logic [LANES-1:0]                  q1,
    output logic                              iddr_ce,
    output logic                              iddr_rst,
    output logic [LANES*WORD_W-1:0]           word_out,
    output logic                              word_valid,
    output logic                              locked,
    output logic                              align_err,
    output logic [LANES*$clog2(WORD_W)-1:0]   slip,
    output logic [2:0]                        fsm_state
);

    localparam int SW = $clog2(WORD_W);
    localparam int PW = $clog2(WORD_W / 2);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int TW = $clog2(2 * WORD_W + 1);
    localparam int CW = $clog2(WORD_W + FLUSH_CYC + 1);

    localparam logic [SW-1:0] OFF_LAST   = SW'(WORD_W - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(WORD_W / 2 - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(MATCH_CNT);
    localparam logic [TW-1:0] TRY_MAX    = TW'(2 * WORD_W);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] FILL_LAST  = CW'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_FILL   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t state;
    state_t nxt;

    logic [CW-1:0]       cnt;
    logic [PW-1:0]       ph;
    logic                boundary;

    logic [2*WORD_W-1:0] sr        [LANES];
    logic [SW-1:0]       off       [LANES];
    logic [MW-1:0]       mcnt      [LANES];
    logic [TW-1:0]       tries     [LANES];

    logic [WORD_W-1:0]   lane_word [LANES];
    logic [SW-1:0]       off_nxt   [LANES];
    logic [MW-1:0]       mcnt_nxt  [LANES];
    logic [TW-1:0]       tries_nxt [LANES];
    logic [LANES*WORD_W-1:0] words;
    logic                all_match;
    logic                any_fail;

    // Word boundary: last phase of a word (only meaningful in SEARCH/LOCKED)
    assign boundary = (ph == PH_LAST);

    // State register; reset wins over everything
    always_ff @(posedge C0) begin
        if (R) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic; a train pulse restarts training from any state
    always_comb begin
        nxt = state;
        if (train) begin
            nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:   nxt = ST_IDLE;
                ST_FLUSH:  if (cnt == FLUSH_LAST) nxt = ST_FILL;
                ST_FILL:   if (cnt == FILL_LAST) nxt = ST_SEARCH;
                ST_SEARCH: begin
                    if (boundary) begin
                        if (all_match) begin
                            nxt = ST_LOCKED;
                        end else if (any_fail) begin
                            nxt = ST_FAIL;
                        end
                    end
                end
                ST_LOCKED: nxt = ST_LOCKED;
                ST_FAIL:   nxt = ST_FAIL;
                default:   nxt = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        iddr_ce   = 1'b0;
        iddr_rst  = 1'b0;
        locked    = 1'b0;
        align_err = 1'b0;
        case (state)
            ST_FLUSH:  iddr_rst  = 1'b1;
            ST_FILL:   iddr_ce   = 1'b1;
            ST_SEARCH: iddr_ce   = 1'b1;
            ST_LOCKED: begin
                iddr_ce = 1'b1;
                locked  = 1'b1;
            end
            ST_FAIL:   align_err = 1'b1;
            default:   iddr_ce   = 1'b0;
        endcase
    end

    assign fsm_state = state;

    // Dwell counter for FLUSH and FILL; restarts on every state change or train
    always_ff @(posedge C0) begin
        if (R) begin
            cnt <= '0;
        end else if (train || (nxt != state)) begin
            cnt <= '0;
        end else if ((state == ST_FLUSH) || (state == ST_FILL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Word phase: held at 0 through FILL, free-running while the IDDR2 is enabled
    always_ff @(posedge C0) begin
        if (R) begin
            ph <= '0;
        end else if (train || (state == ST_FILL)) begin
            ph <= '0;
        end else if (iddr_ce) begin
            ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
        end
    end

    // Per-lane word extraction and the candidate update for a search boundary
    always_comb begin
        all_match = 1'b1;
        any_fail  = 1'b0;
        words     = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_word[l] = sr[l][off[l] +: WORD_W];
            words[l*WORD_W +: WORD_W] = lane_word[l];
            if (lane_word[l] == TRAIN_PAT) begin
                mcnt_nxt[l]  = (mcnt[l] == MATCH_MAX) ? MATCH_MAX : mcnt[l] + 1'b1;
                off_nxt[l]   = off[l];
                tries_nxt[l] = tries[l];
            end else begin
                mcnt_nxt[l]  = '0;
                off_nxt[l]   = (off[l] == OFF_LAST) ? '0 : off[l] + 1'b1;
                tries_nxt[l] = (tries[l] == TRY_MAX) ? TRY_MAX : tries[l] + 1'b1;
            end
            if (mcnt_nxt[l] != MATCH_MAX) all_match = 1'b0;
            if (tries_nxt[l] == TRY_MAX)  any_fail  = 1'b1;
        end
    end

    // Per-lane history shift plus slip/match/try bookkeeping
    always_ff @(posedge C0) begin
        if (R) begin
            for (int l = 0; l < LANES; l++) begin
                sr[l]    <= '0;
                off[l]   <= '0;
                mcnt[l]  <= '0;
                tries[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                sr[l] <= {sr[l][2*WORD_W-3:0], q0[l], q1[l]};
                if (train) begin
                    off[l]   <= '0;
                    mcnt[l]  <= '0;
                    tries[l] <= '0;
                end else if ((state == ST_SEARCH) && boundary) begin
                    off[l]   <= off_nxt[l];
                    mcnt[l]  <= mcnt_nxt[l];
                    tries[l] <= tries_nxt[l];
                end
            end
        end
    end

    // Aligned word register: captured once per boundary while locked
    always_ff @(posedge C0) begin
        if (R) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if ((state == ST_LOCKED) && boundary && !train) begin
                word_out   <= words;
                word_valid <= 1'b1;
            end
        end
    end

    // Pack per-lane offsets onto the slip bus
    always_comb begin
        slip = '0;
        for (int l = 0; l < LANES; l++) begin
            slip[l*SW +: SW] = off[l];
        end
    end

endmodule

// File: tb/tb_iddr2_rx_align.sv
// tb_iddr2_rx_align: scenario bench for the IDDR2 word-alignment controller.
// Each lane is driven from a bit stream position 2*gcnt (q0) / 2*gcnt+1 (q1);
// bit t of a lane is pat[7 - ((t + skew) % 8)]. Training pulses are issued on
// cycles where gcnt % 4 == 0 so an unskewed lane is word-aligned at slip 0 and a
// skew-3 lane aligns at slip 3.
module tb_iddr2_rx_align;

    localparam int LANES  = 2;
    localparam int WORD_W = 8;
    localparam int SW     = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH  = 3'd1;
    localparam logic [2:0] S_FILL   = 3'd2;
    localparam logic [2:0] S_SEARCH = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic                      C0 = 1'b0;
    logic                      R = 1'b0;
    logic                      train = 1'b0;
    logic [LANES-1:0]          q0 = '0;
    logic [LANES-1:0]          q1 = '0;
    logic                      iddr_ce;
    logic                      iddr_rst;
    logic [LANES*WORD_W-1:0]   word_out;
    logic                      word_valid;
    logic                      locked;
    logic                      align_err;
    logic [LANES*SW-1:0]       slip;
    logic [2:0]                fsm_state;

    int errors = 0;
    int checks = 0;
    int gcnt   = 0;

    logic [7:0]  lp  [LANES];
    int          lsk [LANES];
    bit          lz  [LANES];
    logic [15:0] exp_q[$];

    iddr2_rx_align #(
        .LANES(LANES), .WORD_W(WORD_W), .TRAIN_PAT(8'hA5),
        .MATCH_CNT(4), .FLUSH_CYC(4)
    ) dut (
        .C0(C0), .R(R), .train(train), .q0(q0), .q1(q1),
        .iddr_ce(iddr_ce), .iddr_rst(iddr_rst), .word_out(word_out),
        .word_valid(word_valid), .locked(locked), .align_err(align_err),
        .slip(slip), .fsm_state(fsm_state)
    );

    // Clock
    always #5 C0 = ~C0;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock: drive lane bits for this edge, sample #1 after it
    task automatic tick();
        int t;
        t = 2 * gcnt;
        for (int l = 0; l < LANES; l++) begin
            q0[l] = lz[l] ? 1'b0 : lp[l][7 - ((t + lsk[l]) % 8)];
            q1[l] = lz[l] ? 1'b0 : lp[l][7 - ((t + 1 + lsk[l]) % 8)];
        end
        @(posedge C0);
        #1;
        gcnt++;
        checks++;
        if (word_valid && !locked) begin
            errors++;
            $display("FAIL strobe_outside_locked: word_valid=%b locked=%b, required word_valid=0",
                     word_valid, locked);
        end
    endtask

    // Align to a word slot, then pulse train for one cycle
    task automatic pulse_train();
        while ((gcnt % 4) != 0) tick();
        train = 1'b1;
        tick();
        train = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1;
        tick();
        tick();
        R = 1'b0;
        repeat (10) tick();
        checks++;
        if ({iddr_ce, iddr_rst, locked, align_err, word_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ce/rst/locked/err/valid=%b, required 00000",
                     {iddr_ce, iddr_rst, locked, align_err, word_valid});
        end
        checks++;
        if (slip !== 6'd0) begin
            errors++;
            $display("FAIL reset_slip: got %b, required 000000", slip);
        end
        checks++;
        if (word_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_word_out: got %h, required 0000", word_out);
        end
        checks++;
        if (fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d, required %0d", fsm_state, S_IDLE);
        end
    endtask

    task automatic test_flush();
        pulse_train();
        checks++;
        if ({iddr_rst, iddr_ce} !== 2'b10) begin
            errors++;
            $display("FAIL flush_start: rst/ce=%b, required 10", {iddr_rst, iddr_ce});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({iddr_rst, iddr_ce} !== 2'b10) begin
                errors++;
                $display("FAIL flush_hold%0d: rst/ce=%b, required 10", i, {iddr_rst, iddr_ce});
            end
        end
        tick();
        checks++;
        if ({iddr_rst, iddr_ce} !== 2'b01 || fsm_state !== S_FILL) begin
            errors++;
            $display("FAIL fill_start: rst/ce=%b state=%0d, required 01 state=%0d",
                     {iddr_rst, iddr_ce}, fsm_state, S_FILL);
        end
    endtask

    task automatic test_search();
        repeat (11) tick();
        checks++;
        if (slip !== 6'b000_000 || fsm_state !== S_SEARCH) begin
            errors++;
            $display("FAIL before_first_boundary: slip=%b state=%0d, required 000000 state=%0d",
                     slip, fsm_state, S_SEARCH);
        end
        tick();
        checks++;
        if (slip !== 6'b000_001) begin
            errors++;
            $display("FAIL first_boundary_slip: got %b, required 000001", slip);
        end
        repeat (23) tick();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL locked_early: got %b, required 0", locked);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || fsm_state !== S_LOCKED) begin
            errors++;
            $display("FAIL lock: locked=%b state=%0d, required 1 state=%0d",
                     locked, fsm_state, S_LOCKED);
        end
        checks++;
        if (slip !== 6'b000_011) begin
            errors++;
            $display("FAIL lock_slip: got %b, required 000011", slip);
        end
    endtask

    task automatic test_locked_stream();
        int seen;
        int last;
        logic [15:0] exp;
        seen = 0;
        last = -1;
        while ((gcnt % 4) != 0) tick();
        lp[0] = 8'h3C;
        lp[1] = 8'hC3;
        repeat (8) tick();
        for (int w = 0; w < 5; w++) begin
            exp_q.push_back(16'hC33C);
            for (int c = 0; c < 4; c++) begin
                tick();
                if (word_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: word_out=%h, required no strobe", word_out);
                    end else begin
                        exp = exp_q.pop_front();
                        if (word_out !== exp) begin
                            errors++;
                            $display("FAIL stream_word: got %h, required %h", word_out, exp);
                        end
                    end
                    if (last >= 0) begin
                        checks++;
                        if (gcnt - last != 4) begin
                            errors++;
                            $display("FAIL strobe_gap: got %0d cycles, required 4", gcnt - last);
                        end
                    end
                    last = gcnt;
                    seen++;
                end
            end
        end
        checks++;
        if (seen != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL strobe_count: got %0d strobes (%0d pending), required 5 (0 pending)",
                     seen, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_train_while_locked();
        pulse_train();
        checks++;
        if (locked !== 1'b0 || iddr_rst !== 1'b1 || fsm_state !== S_FLUSH) begin
            errors++;
            $display("FAIL retrain_locked: locked=%b rst=%b state=%0d, required 0 1 state=%0d",
                     locked, iddr_rst, fsm_state, S_FLUSH);
        end
        checks++;
        if (slip !== 6'd0 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL retrain_clear: slip=%b valid=%b, required 000000 0", slip, word_valid);
        end
    endtask

    task automatic test_flush_restart();
        int n;
        tick();
        train = 1'b1;
        tick();
        train = 1'b0;
        n = iddr_rst ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (iddr_rst) n++;
        end
        tick();
        checks++;
        if (n != 4 || {iddr_rst, iddr_ce} !== 2'b01) begin
            errors++;
            $display("FAIL flush_restart: rst cycles=%0d rst/ce=%b, required 4 cycles then 01",
                     n, {iddr_rst, iddr_ce});
        end
    endtask

    task automatic test_reset_mid_search();
        lp[0] = 8'hA5;
        lp[1] = 8'hA5;
        pulse_train();
        repeat (20) tick();
        checks++;
        if (slip !== 6'b000_010 || fsm_state !== S_SEARCH) begin
            errors++;
            $display("FAIL mid_search: slip=%b state=%0d, required 000010 state=%0d",
                     slip, fsm_state, S_SEARCH);
        end
        R = 1'b1;
        train = 1'b1;
        tick();
        R = 1'b0;
        train = 1'b0;
        checks++;
        if ({iddr_ce, iddr_rst, locked, align_err, word_valid} !== 5'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_priority: ctrl=%b state=%0d, required 00000 state=%0d",
                     {iddr_ce, iddr_rst, locked, align_err, word_valid}, fsm_state, S_IDLE);
        end
        checks++;
        if (slip !== 6'd0 || word_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_clear: slip=%b word_out=%h, required 000000 0000", slip, word_out);
        end
    endtask

    task automatic test_fail();
        lz[1]  = 1'b1;
        lsk[0] = 0;
        pulse_train();
        repeat (75) tick();
        checks++;
        if (align_err !== 1'b0 || iddr_ce !== 1'b1) begin
            errors++;
            $display("FAIL fail_early: err=%b ce=%b, required 0 1", align_err, iddr_ce);
        end
        tick();
        checks++;
        if ({align_err, iddr_ce, locked} !== 3'b100 || fsm_state !== S_FAIL) begin
            errors++;
            $display("FAIL fail_enter: err/ce/locked=%b state=%0d, required 100 state=%0d",
                     {align_err, iddr_ce, locked}, fsm_state, S_FAIL);
        end
        repeat (6) tick();
        checks++;
        if (align_err !== 1'b1) begin
            errors++;
            $display("FAIL fail_sticky: err=%b, required 1", align_err);
        end
        pulse_train();
        checks++;
        if (align_err !== 1'b0 || iddr_rst !== 1'b1) begin
            errors++;
            $display("FAIL fail_clear: err=%b rst=%b, required 0 1", align_err, iddr_rst);
        end
    endtask

    initial begin
        lp[0]  = 8'hA5;
        lp[1]  = 8'hA5;
        lsk[0] = 3;
        lsk[1] = 0;
        lz[0]  = 1'b0;
        lz[1]  = 1'b0;
        test_reset();
        test_flush();
        test_search();
        test_locked_stream();
        test_train_while_locked();
        test_flush_restart();
        test_reset_mid_search();
        test_fail();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
